// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/de/coordinate generator; define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 64,
  parameter int   H_BP      = 80,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 13,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CW        = 11
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic          frame_start,
  output logic [15:0]   frame_cnt
`else
  output logic          frame_start
`endif
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_VISIBLE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VISIBLE + V_FP;
  localparam int HA = H_SYNC + H_BP;
  localparam int HE = HA + H_VISIBLE;
  localparam int VA = V_SYNC + V_BP;
  localparam int VE = VA + V_VISIBLE;
  logic [CW-1:0] hc, vc, hc_n, vc_n;
  logic h_wrap, h_vis_n, v_vis_n, de_n, first_n;
  // next counter value and its decode; outputs are loaded from this so they track the counters
  always_comb begin
    h_wrap  = hc == CW'(H_TOTAL - 1);
    hc_n    = h_wrap ? '0 : hc + 1'b1;
    vc_n    = h_wrap ? ((vc == CW'(V_TOTAL - 1)) ? '0 : vc + 1'b1) : vc;
    h_vis_n = 32'(hc_n) >= HA && 32'(hc_n) < HE;
    v_vis_n = 32'(vc_n) >= VA && 32'(vc_n) < VE;
    de_n    = h_vis_n && v_vis_n;
    first_n = hc_n == '0;
  end
  // counters and registered outputs advance together on pixel-enable edges
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      hs          <= HS_POL;
      vs          <= VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hc          <= hc_n;
      vc          <= vc_n;
      hs          <= (32'(hc_n) < H_SYNC) ? HS_POL : !HS_POL;
      vs          <= (32'(vc_n) < V_SYNC) ? VS_POL : !VS_POL;
      de          <= de_n;
      x           <= de_n ? hc_n - CW'(HA) : '0;
      y           <= v_vis_n ? vc_n - CW'(VA) : '0;
      line_start  <= first_n;
      frame_start <= first_n && vc_n == '0;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  // counts frame_start rising into the held pixel; wraps naturally at 16 bits
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (ce && first_n && vc_n == '0) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: the successor to the fixed 640x480 driver. It produces sync pulses, a data-enable, 0-based visible pixel coordinates and line/frame start markers for any mode set by parameters. A pixel clock-enable lets it run from a fast system clock. It sits between the pixel clock domain and the pixel/colour generator; every output is registered and aligned to the same pixel.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 64, horizontal sync width (pixels)
- H_BP, 80, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 13, vertical back porch (lines)
- HS_POL, 0, active level of hs
- VS_POL, 0, active level of vs
- CW, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW

Ports:
- clk_vga  in  1  clock; reset is asynchronous and active-low (rst_n)
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel enable; state advances only on cycles with ce=1
- hs  out  1  horizontal sync, HS_POL while active
- vs  out  1  vertical sync, VS_POL while active
- de  out  1  high inside the visible area
- x  out  CW  0-based visible column; 0 when de=0
- y  out  CW  0-based visible row; 0 when not in a visible line
- line_start  out  1  high for the pixel with hc=0
- frame_start  out  1  high for the pixel with hc=0, vc=0

## Operation
- H_TOTAL = H_SYNC+H_BP+H_VISIBLE+H_FP; V_TOTAL = V_SYNC+V_BP+V_VISIBLE+V_FP. Line order is sync, back porch, visible, front porch; the frame uses the same order.
- Internal counters hc in [0,H_TOTAL-1] and vc in [0,V_TOTAL-1].
- When ce=1: hc increments and wraps from H_TOTAL-1 to 0. vc increments only when hc wraps, so vc changes on the same edge that hc becomes 0. vc wraps from V_TOTAL-1 to 0.
- When ce=0: the counters and all outputs hold.
- Decode, for each (hc,vc):
  - hs active iff hc < H_SYNC.
  - vs active iff vc < V_SYNC.
  - h_vis iff H_SYNC+H_BP ≤ hc < H_SYNC+H_BP+H_VISIBLE; v_vis is the vertical equivalent.
  - de = h_vis & v_vis.
  - x = hc-(H_SYNC+H_BP) when de, else 0.
  - y = vc-(V_SYNC+V_BP) when v_vis, else 0.
- All outputs are flops loaded from the decode of the next counter value, so they always describe the current counter state. There is no combinational path from the counters to the outputs.
- Arithmetic uses CW bits unsigned; there is no overflow given the CW constraint.

## Timing
- Reset (asynchronous, rst_n=0): hc=0, vc=0, hs=HS_POL, vs=VS_POL, de=0, x=0, y=0, line_start=0, frame_start=0.
  - The markers reset to 0 even though hc=vc=0. The first frame_start occurs at the first wrap.
- Reset is deasserted synchronously by the external reset synchroniser. The first counted pixel is the first ce=1 edge after release (hc becomes 1).
- Reset mid-frame returns everything to the reset state immediately; no partial-frame recovery is attempted.
- Latency: outputs change on the same edge as the counters (0 cycles relative to the counter state).
- With ce=0 the markers stay high for the whole held pixel. They are per-pixel levels, not single-clk pulses.
- Mode changes are static: parameters only, with no runtime reprogramming.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output frame_cnt [15:0], reset 0.
  - It increments on every edge where frame_start becomes 1, and wraps from 65535 to 0.
- VGA_TIMING_FRAME_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Defaults, ce=1 constant, release reset, count edges k from 1:
  - hs low (HS_POL=0) through k=63, high at k=64.
  - First de=1 at k=17*800+144=13744 with x=0, y=0.
- Defaults, end of active area:
  - de=1 with x=639, y=479 at hc=783, vc=496; de=0 at hc=784.
  - frame_start and line_start high together every 400000 edges.
  - vs low for exactly 4*800=3200 edges per frame.
- 1024x768 mode (H 1024/24/136/160, V 768/3/6/29, CW=11), ce=1:
  - Line period 1344 edges; frame period 1344*806=1083264 edges.
  - x reaches 1023, y reaches 767.
- Defaults, ce high one cycle in four:
  - hs low for 256 clk_vga cycles.
  - Every output changes only on ce=1 edges.
  - line_start stays high for 4 clks per line.
- Assert rst_n=0 mid-frame at vc=200, hc=400:
  - All outputs take reset values asynchronously, before the next edge.
  - After release the sequence restarts from hc=0, vc=0.
- VGA_TIMING_FRAME_CNT_EN defined, defaults:
  - frame_cnt=0 after reset and =1 after the first frame_start.
  - Force-run 65536 frames (or preload via a bench hierarchy force) and check wrap to 0.
